time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock_pkg.sv | 27 ++
 rtl/key_repeat.sv | 60 ++++++
 rtl/time_set_ctrl.sv | 176 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day display/set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_e;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    localparam int unsigned MASK_HH = 2;
    localparam int unsigned MASK_MM = 1;
    localparam int unsigned MASK_SS = 0;

    // +/-1 modulo (max+1), no carry out
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
        if (up) begin
            return (val == max) ? 6'd0 : val + 6'd1;
        end
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detector with hold-to-repeat; emits a registered one-cycle step pulse.
module key_repeat #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    input  logic i_clear,
    output logic o_step
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

    logic          r_hist;
    logic          r_rep;
    logic [CW-1:0] r_cnt;
    logic          r_step;
    logic          w_rise;
    logic          w_fire;

    // r_cnt holds the number of cycles the key has been seen high since the last (re)start
    always_comb begin
        w_rise = i_key & ~r_hist;
        w_fire = 1'b0;
        if (i_key && r_hist) begin
            w_fire = r_rep ? (r_cnt == RATE_C) : (r_cnt == DELAY_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b1;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else begin
            r_hist <= i_key;
            r_step <= (w_rise | w_fire) & ~i_clear;
            if (!i_key) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (i_clear || w_rise) begin
                r_cnt <= CW'(1);
                r_rep <= 1'b0;
            end else if (w_fire) begin
                r_cnt <= CW'(1);
                r_rep <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-keeping with a RUN/SET_H/SET_M/SET_S mode machine, key auto-repeat,
// set-mode inactivity timeout and a blinking mask for the field being edited.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned BLINK_HALF   = 25000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic [1:0] mode,
    output logic [2:0] blink_mask,
    output logic       day_pulse
);

    localparam int unsigned TW  = $clog2(TIMEOUT_S + 1);
    localparam int unsigned BLW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0]  TO_C    = TW'(TIMEOUT_S);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);

    mode_e          r_state;
    mode_e          w_state_nxt;
    logic [4:0]     r_hh;
    logic [5:0]     r_mm;
    logic [5:0]     r_ss;
    logic [4:0]     w_hh_nxt;
    logic [5:0]     w_mm_nxt;
    logic [5:0]     w_ss_nxt;
    logic           r_day;
    logic [TW-1:0]  r_to;
    logic [BLW-1:0] r_blink_cnt;
    logic           r_phase;
    logic           r_mode_hist;
    logic           r_mode_press;
    logic           w_up_step;
    logic           w_dn_step;
    logic           w_set;
    logic           w_adj;
    logic           w_any;
    logic           w_tick_run;
    logic           w_timeout;
    logic           w_rollover;
    logic [2:0]     w_mask;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_up (
        .clk     (clk),
        .rst     (rst),
        .i_key   (key_up),
        .i_clear (key_up & key_down),
        .o_step  (w_up_step)
    );

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_dn (
        .clk     (clk),
        .rst     (rst),
        .i_key   (key_down),
        .i_clear (key_up & key_down),
        .o_step  (w_dn_step)
    );

    // A mode press in the same cycle swallows any up/down step
    assign w_set      = (r_state != RUN);
    assign w_adj      = w_set & ~r_mode_press & (w_up_step ^ w_dn_step);
    assign w_any      = r_mode_press | w_up_step | w_dn_step;
    assign w_tick_run = tick_1hz & ~w_set;
    assign w_timeout  = w_set & (r_to == TO_C);
    assign w_rollover = w_tick_run & (r_ss == MS_MAX) & (r_mm == MS_MAX) & (r_hh == HH_MAX);

    always_comb begin
        w_state_nxt = r_state;
        if (r_mode_press) begin
            unique case (r_state)
                RUN:   w_state_nxt = SET_H;
                SET_H: w_state_nxt = SET_M;
                SET_M: w_state_nxt = SET_S;
                SET_S: w_state_nxt = RUN;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = RUN;
        end
    end

    always_comb begin
        w_hh_nxt = r_hh;
        w_mm_nxt = r_mm;
        w_ss_nxt = r_ss;
        if (w_tick_run) begin
            w_ss_nxt = wrap_step(r_ss, MS_MAX, 1'b1);
            if (r_ss == MS_MAX) begin
                w_mm_nxt = wrap_step(r_mm, MS_MAX, 1'b1);
                if (r_mm == MS_MAX) begin
                    w_hh_nxt = 5'(wrap_step({1'b0, r_hh}, {1'b0, HH_MAX}, 1'b1));
                end
            end
        end else if (w_adj) begin
            case (r_state)
                SET_H:   w_hh_nxt = 5'(wrap_step({1'b0, r_hh}, {1'b0, HH_MAX}, w_up_step));
                SET_M:   w_mm_nxt = wrap_step(r_mm, MS_MAX, w_up_step);
                SET_S:   w_ss_nxt = wrap_step(r_ss, MS_MAX, w_up_step);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_mask = '0;
        case (r_state)
            SET_H:   w_mask[MASK_HH] = r_phase;
            SET_M:   w_mask[MASK_MM] = r_phase;
            SET_S:   w_mask[MASK_SS] = r_phase;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_hh         <= '0;
            r_mm         <= '0;
            r_ss         <= '0;
            r_day        <= 1'b0;
            r_to         <= '0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_mode_hist  <= 1'b1;
            r_mode_press <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hh         <= w_hh_nxt;
            r_mm         <= w_mm_nxt;
            r_ss         <= w_ss_nxt;
            r_day        <= w_rollover;
            r_mode_hist  <= key_mode;
            r_mode_press <= key_mode & ~r_mode_hist;

            if (w_any || !w_set || (w_state_nxt != r_state)) begin
                r_to <= '0;
            end else if (tick_1hz) begin
                r_to <= r_to + TW'(1);
            end

            if (w_any) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == BL_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLW'(1);
            end
        end
    end

    assign hh         = r_hh;
    assign mm         = r_mm;
    assign ss         = r_ss;
    assign mode       = r_state;
    assign blink_mask = w_mask;
    assign day_pulse  = r_day;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed corner cases, then random key/tick traffic
// checked against a seconds-of-day reference model.
module tb_time_set_ctrl;

    localparam int BH = 16;
    localparam int RD = 10;
    localparam int RR = 4;
    localparam int TO = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic       km   = 1'b0;
    logic       ku   = 1'b0;
    logic       kd   = 1'b0;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [1:0] mode;
    logic [2:0] mask;
    logic       day;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int    at;
        int    hh;
        int    mm;
        int    ss;
        int    mode;
        int    mask;
        bit    day;
        bit    cm;
        string name;
    } exp_t;

    exp_t sb[$];

    // Reference model: time as seconds of day, mode as 0..3
    int m_sec    = 0;
    int m_mode   = 0;
    int m_to     = 0;
    int m_ref    = 0;
    int m_day_at = -1;

    time_set_ctrl #(
        .BLINK_HALF   (BH),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .TIMEOUT_S    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick),
        .key_mode   (km),
        .key_up     (ku),
        .key_down   (kd),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .mode       (mode),
        .blink_mask (mask),
        .day_pulse  (day)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if (e.at != cyc) begin
                n_err++;
                $display("FAIL %s: slot for cycle %0d missed, now cycle %0d", e.name, e.at, cyc);
            end else if (int'(hh) != e.hh || int'(mm) != e.mm || int'(ss) != e.ss ||
                         int'(mode) != e.mode || day != e.day ||
                         (e.cm && int'(mask) != e.mask)) begin
                n_err++;
                $display("FAIL %s @%0d: got %0d:%0d:%0d mode=%0d mask=%0d day=%0d, want %0d:%0d:%0d mode=%0d mask=%0d day=%0d",
                         e.name, cyc, hh, mm, ss, mode, mask, day,
                         e.hh, e.mm, e.ss, e.mode, e.mask, e.day);
            end
        end
    end

    function automatic void model_reset();
        m_sec    = 0;
        m_mode   = 0;
        m_to     = 0;
        m_ref    = 0;
        m_day_at = -1;
    endfunction

    // which: 0 tick, 1 mode, 2 up, 3 down; c = cycle count when the input is driven
    function automatic void model_op(input int which, input int c);
        int h, m, s, d;
        h = m_sec / 3600;
        m = (m_sec / 60) % 60;
        s = m_sec % 60;
        case (which)
            0: begin
                if (m_mode == 0) begin
                    m_sec = (m_sec + 1) % 86400;
                    if (m_sec == 0) m_day_at = c + 1;
                end else begin
                    m_to++;
                    if (m_to >= TO) begin
                        m_mode = 0;
                        m_to   = 0;
                    end
                end
            end
            1: begin
                m_mode = (m_mode + 1) % 4;
                m_to   = 0;
                m_ref  = c + 2;
            end
            default: begin
                if (m_mode != 0) begin
                    d = (which == 2) ? 1 : -1;
                    case (m_mode)
                        1:       h = (h + d + 24) % 24;
                        2:       m = (m + d + 60) % 60;
                        default: s = (s + d + 60) % 60;
                    endcase
                    m_sec = h * 3600 + m * 60 + s;
                    m_to  = 0;
                    m_ref = c + 2;
                end
            end
        endcase
    endfunction

    function automatic int exp_mask(input int t);
        if (m_mode == 0) return 0;
        return (((t - m_ref) / BH) % 2) << (3 - m_mode);
    endfunction

    task automatic push(input int t, input string name, input int h, input int m, input int s,
                        input int md, input int mk, input bit cm);
        exp_t e;
        e.at   = t;
        e.hh   = h;
        e.mm   = m;
        e.ss   = s;
        e.mode = md;
        e.mask = mk;
        e.day  = (m_day_at == t);
        e.cm   = cm;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_model(input int t, input string name, input bit cm);
        push(t, name, m_sec / 3600, (m_sec / 60) % 60, m_sec % 60, m_mode, exp_mask(t), cm);
    endtask

    task automatic drive(input int which);
        case (which)
            0:       tick = 1'b1;
            1:       km = 1'b1;
            2:       ku = 1'b1;
            default: kd = 1'b1;
        endcase
        model_op(which, cyc);
    endtask

    task automatic release_keys();
        @(negedge clk);
        tick = 1'b0;
        km   = 1'b0;
        ku   = 1'b0;
        kd   = 1'b0;
    endtask

    task automatic op(input int which);
        drive(which);
        release_keys();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic op_idle(input int which);
        op(which);
        idle(3);
    endtask

    task automatic expect_next(input string name, input bit cm);
        push_model(cyc + 1, name, cm);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d, bench did not finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, e, gap, w;

        // Reset with keys held through it
        km = 1'b1;
        ku = 1'b1;
        idle(3);
        expect_next("reset_vals", 1);
        rst = 1'b0;
        model_reset();
        idle(4);
        expect_next("held_mode_no_press", 1);
        release_keys();
        idle(3);

        // Preset 23:59:58 through the set modes, then roll over
        op_idle(1); op_idle(3);
        op_idle(1); op_idle(3);
        op_idle(1); op_idle(3); op_idle(3);
        op_idle(1);
        expect_next("preset_235958", 1);
        drive(0);
        push_model(cyc + 1, "tick_235959", 1);
        release_keys();
        idle(2);
        drive(0);
        push_model(cyc + 1, "rollover_day_pulse", 1);
        release_keys();
        push_model(cyc + 1, "day_pulse_one_cycle", 1);
        idle(3);

        // hh=22, back to RUN, then SET_H and three ups
        op_idle(1); op_idle(3); op_idle(3);
        op_idle(1); op_idle(1); op_idle(1);
        expect_next("run_at_22", 1);
        op_idle(1);
        op_idle(2); op_idle(2); op_idle(2);
        expect_next("seth_up3_wrap", 1);

        // Up and down together: no step
        ku = 1'b1;
        kd = 1'b1;
        release_keys();
        idle(3);
        expect_next("up_down_cancel", 1);

        // Mode and up together: mode wins
        km = 1'b1;
        ku = 1'b1;
        model_op(1, cyc);
        release_keys();
        idle(3);
        expect_next("mode_beats_up", 1);

        // SET_M down from 0: no borrow
        op_idle(3);
        expect_next("mm_down_wrap", 1);

        // Blink phase boundaries
        e = m_ref;
        push_model(e + BH - 1, "blink_before_toggle", 1);
        push_model(e + BH, "blink_toggle_on", 1);
        push_model(e + 2 * BH, "blink_toggle_off", 1);
        while (cyc <= e + 2 * BH) @(negedge clk);

        // Hold up for 30 cycles in SET_S
        op_idle(1);
        c = cyc;
        ku = 1'b1;
        push(c + 11, "hold_before_repeat", m_sec / 3600, (m_sec / 60) % 60, m_sec % 60 + 1, 3, 0, 0);
        push(c + 12, "hold_first_repeat", m_sec / 3600, (m_sec / 60) % 60, m_sec % 60 + 2, 3, 0, 0);
        idle(30);
        ku = 1'b0;
        for (int i = 0; i < 6; i++) model_op(2, c);
        m_ref = c + 28;
        idle(3);
        expect_next("hold_30_cycles", 1);

        // Timeout back to RUN from SET_H
        op_idle(1); op_idle(1);
        op_idle(0); op_idle(0);
        expect_next("set_two_ticks", 1);
        drive(0);
        c = cyc;
        push(c + 1, "timeout_not_yet", m_sec / 3600, (m_sec / 60) % 60, m_sec % 60, 1, 0, 0);
        push_model(c + 2, "timeout_to_run", 1);
        release_keys();
        idle(3);
        op(0);
        idle(2);
        expect_next("tick_after_timeout", 1);

        // Tick coinciding with mode press in RUN
        c = cyc;
        km = 1'b1;
        @(negedge clk);
        km   = 1'b0;
        tick = 1'b1;
        model_op(0, c + 1);
        model_op(1, c);
        release_keys();
        idle(2);
        expect_next("tick_with_mode", 1);

        // Reset mid-repeat in SET_H, key still held afterwards
        drive(2);
        idle(12);
        rst = 1'b1;
        model_reset();
        push_model(cyc + 1, "reset_mid_repeat", 1);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        expect_next("held_through_reset", 1);
        release_keys();
        idle(3);

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            w = int'($urandom_range(0, 5));
            c = cyc;
            op((w >= 4) ? 0 : w);
            gap = int'($urandom_range(3, 6));
            push_model(c + gap + 1, "random_op", 1);
            while (cyc < c + gap + 1) @(negedge clk);
        end

        idle(3);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
